// File: rtl/timer_entry_loader.sv
// ============================================================================
// Module   : timer_entry_loader
// Brief    : Keypad M:SS entry, validation and parallel-load/start sequencing
//            for the BCD countdown timer chain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_entry_loader #(
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_clear,
  input  logic       start,
  input  logic       running,
  output logic       loadn,
  output logic [3:0] data_sec_ones,
  output logic [3:0] data_sec_tens,
  output logic [3:0] data_min_ones,
  output logic [1:0] digit_count,
  output logic       start_out,
  output logic       cancel,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_ARM   = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  localparam logic [3:0] c_max_sec_tens = 4'(MAX_SEC_TENS);

  state_t     r_state;
  logic       r_loadn;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [1:0] r_digit_count;
  logic       r_start_out;
  logic       r_cancel;
  logic       r_err;
  logic       r_busy;

  logic w_digit;
  logic w_tens_bad;

  assign w_digit    = key_valid && (key_code <= 4'd9);
  assign w_tens_bad = r_sec_tens > c_max_sec_tens;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_state       <= S_IDLE;
      r_loadn       <= 1'b1;
      r_sec_ones    <= 4'd0;
      r_sec_tens    <= 4'd0;
      r_min_ones    <= 4'd0;
      r_digit_count <= 2'd0;
      r_start_out   <= 1'b0;
      r_cancel      <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_loadn     <= 1'b1;
      r_start_out <= 1'b0;
      r_cancel    <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE, S_ENTRY: begin
          if (key_clear) begin
            r_sec_ones    <= 4'd0;
            r_sec_tens    <= 4'd0;
            r_min_ones    <= 4'd0;
            r_digit_count <= 2'd0;
            r_state       <= S_IDLE;
          end else if (start) begin
            // A digit arriving with start is dropped; IDLE implies an empty buffer.
            if (r_state == S_ENTRY) begin
              if (w_tens_bad) begin
                r_err <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_loadn <= 1'b0;
                r_busy  <= 1'b1;
              end
            end
          end else if (w_digit && (r_digit_count != 2'd3)) begin
            r_min_ones    <= r_sec_tens;
            r_sec_tens    <= r_sec_ones;
            r_sec_ones    <= key_code;
            r_digit_count <= r_digit_count + 2'd1;
            r_state       <= S_ENTRY;
          end
        end
        S_LOAD: begin
          r_state     <= S_ARM;
          r_start_out <= 1'b1;
        end
        S_ARM: begin
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (key_clear || !running) begin
            r_cancel      <= key_clear;
            r_sec_ones    <= 4'd0;
            r_sec_tens    <= 4'd0;
            r_min_ones    <= 4'd0;
            r_digit_count <= 2'd0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign loadn         = r_loadn;
  assign data_sec_ones = r_sec_ones;
  assign data_sec_tens = r_sec_tens;
  assign data_min_ones = r_min_ones;
  assign digit_count   = r_digit_count;
  assign start_out     = r_start_out;
  assign cancel        = r_cancel;
  assign err           = r_err;
  assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_timer_entry_loader.sv
// ============================================================================
// Module   : tb_timer_entry_loader
// Brief    : Directed scoreboard bench for timer_entry_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timer_entry_loader;

  logic       clock;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_clear;
  logic       start;
  logic       running;
  logic       loadn;
  logic [3:0] data_sec_ones;
  logic [3:0] data_sec_tens;
  logic [3:0] data_min_ones;
  logic [1:0] digit_count;
  logic       start_out;
  logic       cancel;
  logic       err;
  logic       busy;

  timer_entry_loader #(.MAX_SEC_TENS(5)) dut (
    .clock        (clock),
    .clrn         (clrn),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_clear    (key_clear),
    .start        (start),
    .running      (running),
    .loadn        (loadn),
    .data_sec_ones(data_sec_ones),
    .data_sec_tens(data_sec_tens),
    .data_min_ones(data_min_ones),
    .digit_count  (digit_count),
    .start_out    (start_out),
    .cancel       (cancel),
    .err          (err),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Vector order: loadn, min, sec_tens, sec_ones, count, start_out, cancel, err, busy
  function automatic logic [18:0] pk(input logic ld, input logic [3:0] mn, input logic [3:0] st,
                                     input logic [3:0] so, input logic [1:0] cnt, input logic sto,
                                     input logic can, input logic er, input logic bz);
    return {ld, mn, st, so, cnt, sto, can, er, bz};
  endfunction

  task automatic check();
    logic [18:0] obs;
    exp_t        e;
    obs = {loadn, data_min_ones, data_sec_tens, data_sec_ones, digit_count,
           start_out, cancel, err, busy};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic kclr, input logic st,
                      input logic run, input string tag, input logic [18:0] ev);
    key_valid = kv;
    key_code  = kc;
    key_clear = kclr;
    start     = st;
    running   = run;
    sb.push_back('{tag, ev});
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    key_clear = 1'b0;
    start     = 1'b0;
    check();
  endtask

  logic [18:0] c_zero;

  initial begin
    c_zero    = pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    clrn      = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    key_clear = 1'b0;
    start     = 1'b0;
    running   = 1'b0;
    #12;
    sb.push_back('{"reset", c_zero});
    check();
    @(negedge clock);
    clrn = 1'b1;

    // 1:30 load and start sequence
    step(1, 4'd1, 0, 0, 0, "k1_d1",    pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    step(1, 4'd3, 0, 0, 0, "k1_d3",    pk(1, 0, 1, 3, 2, 0, 0, 0, 0));
    step(1, 4'd0, 0, 0, 0, "k1_d0",    pk(1, 1, 3, 0, 3, 0, 0, 0, 0));
    step(0, 4'd0, 0, 1, 0, "k1_load",  pk(0, 1, 3, 0, 3, 0, 0, 0, 1));
    step(0, 4'd0, 0, 0, 1, "k1_arm",   pk(1, 1, 3, 0, 3, 1, 0, 0, 1));
    step(0, 4'd0, 0, 0, 1, "k1_busy",  pk(1, 1, 3, 0, 3, 0, 0, 0, 1));
    step(0, 4'd0, 0, 0, 0, "k1_done",  c_zero);

    // invalid seconds-tens
    step(1, 4'd7, 0, 0, 0, "k2_d7",    pk(1, 0, 0, 7, 1, 0, 0, 0, 0));
    step(1, 4'd8, 0, 0, 0, "k2_d8",    pk(1, 0, 7, 8, 2, 0, 0, 0, 0));
    step(0, 4'd0, 0, 1, 0, "k2_err",   pk(1, 0, 7, 8, 2, 0, 0, 1, 0));
    step(0, 4'd0, 0, 0, 0, "k2_after", pk(1, 0, 7, 8, 2, 0, 0, 0, 0));
    step(0, 4'd0, 0, 0, 0, "k2_noload", pk(1, 0, 7, 8, 2, 0, 0, 0, 0));
    step(0, 4'd0, 1, 0, 0, "k2_clear", c_zero);

    // fourth digit ignored, non-digit key ignored
    step(1, 4'd12, 0, 0, 0, "k3_key12", c_zero);
    step(1, 4'd1, 0, 0, 0, "k3_d1",    pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    step(1, 4'd2, 0, 0, 0, "k3_d2",    pk(1, 0, 1, 2, 2, 0, 0, 0, 0));
    step(1, 4'd3, 0, 0, 0, "k3_d3",    pk(1, 1, 2, 3, 3, 0, 0, 0, 0));
    step(1, 4'd4, 0, 0, 0, "k3_d4",    pk(1, 1, 2, 3, 3, 0, 0, 0, 0));
    step(1, 4'd15, 0, 0, 0, "k3_key15", pk(1, 1, 2, 3, 3, 0, 0, 0, 0));
    step(0, 4'd0, 1, 0, 0, "k3_clear", c_zero);

    // clear beats a same-cycle digit
    step(1, 4'd4, 0, 0, 0, "k4_d4",    pk(1, 0, 0, 4, 1, 0, 0, 0, 0));
    step(1, 4'd5, 0, 0, 0, "k4_d5",    pk(1, 0, 4, 5, 2, 0, 0, 0, 0));
    step(1, 4'd9, 1, 0, 0, "k4_clr9",  c_zero);

    // 0:30 run; digit with start dropped; keys ignored while busy
    step(1, 4'd3, 0, 0, 0, "k5_d3",    pk(1, 0, 0, 3, 1, 0, 0, 0, 0));
    step(1, 4'd0, 0, 0, 0, "k5_d0",    pk(1, 0, 3, 0, 2, 0, 0, 0, 0));
    step(1, 4'd7, 0, 1, 0, "k5_load",  pk(0, 0, 3, 0, 2, 0, 0, 0, 1));
    step(0, 4'd0, 0, 0, 1, "k5_arm",   pk(1, 0, 3, 0, 2, 1, 0, 0, 1));
    for (int i = 0; i < 10; i++) begin
      step((i == 3), 4'd9, 0, (i == 5), 1, "k5_busy", pk(1, 0, 3, 0, 2, 0, 0, 0, 1));
    end
    step(0, 4'd0, 0, 0, 0, "k5_done",  c_zero);

    // repeat run cancelled by key_clear
    step(1, 4'd3, 0, 0, 0, "k6_d3",    pk(1, 0, 0, 3, 1, 0, 0, 0, 0));
    step(1, 4'd0, 0, 0, 0, "k6_d0",    pk(1, 0, 3, 0, 2, 0, 0, 0, 0));
    step(0, 4'd0, 0, 1, 0, "k6_load",  pk(0, 0, 3, 0, 2, 0, 0, 0, 1));
    step(0, 4'd0, 0, 0, 1, "k6_arm",   pk(1, 0, 3, 0, 2, 1, 0, 0, 1));
    step(0, 4'd0, 0, 0, 1, "k6_busy",  pk(1, 0, 3, 0, 2, 0, 0, 0, 1));
    step(0, 4'd0, 1, 0, 1, "k6_cancel", pk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    step(0, 4'd0, 0, 0, 1, "k6_idle",  c_zero);

    // start on empty buffer does nothing
    step(0, 4'd0, 0, 1, 0, "k7_empty", c_zero);
    step(0, 4'd0, 0, 0, 0, "k7_quiet", c_zero);

    // async reset during LOAD
    step(1, 4'd1, 0, 0, 0, "k8_d1",    pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    step(1, 4'd0, 0, 0, 0, "k8_d0a",   pk(1, 0, 1, 0, 2, 0, 0, 0, 0));
    step(1, 4'd0, 0, 0, 0, "k8_d0b",   pk(1, 1, 0, 0, 3, 0, 0, 0, 0));
    step(0, 4'd0, 0, 1, 0, "k8_load",  pk(0, 1, 0, 0, 3, 0, 0, 0, 1));
    #2;
    clrn = 1'b0;
    #1;
    sb.push_back('{"k8_async_rst", c_zero});
    check();
    @(negedge clock);
    clrn = 1'b1;
    step(0, 4'd0, 0, 0, 0, "k8_post1", c_zero);
    step(0, 4'd0, 0, 0, 0, "k8_post2", c_zero);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_entry_loader.md
# timer_entry_loader

Keypad-side writer for the microwave countdown timer chain. Collects up to three decimal digits as M:SS, validates them, and drives the parallel-load interface of the BCD down-counter chain: one-cycle active-low load strobe plus per-digit data. It then issues a one-cycle start strobe and waits for the timer to finish or for the user to cancel.

## Interface
Parameters:
- MAX_SEC_TENS, 5, highest legal seconds-tens digit; a larger value is rejected at start.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe: key_code holds a new key.
- key_code  in  4  key value; 0-9 are digits, 10-15 are ignored.
- key_clear  in  1  one-cycle strobe: clear the entry, or cancel while busy.
- start  in  1  one-cycle strobe: load and run.
- running  in  1  high while the timer chain is counting (not at zero).
- loadn  out  1  active-low parallel-load strobe to the counter chain.
- data_sec_ones  out  4  BCD seconds-ones for the load.
- data_sec_tens  out  4  BCD seconds-tens for the load.
- data_min_ones  out  4  BCD minutes-ones for the load.
- digit_count  out  2  number of digits entered, 0-3.
- start_out  out  1  one-cycle enable-begin strobe to the timer.
- cancel  out  1  one-cycle abort strobe to the timer.
- err  out  1  one-cycle strobe: invalid entry rejected.
- busy  out  1  high in states LOAD, ARM and BUSY.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE;
  - all data digits 0;
  - digit_count 0;
  - loadn 1;
  - start_out, cancel and err 0;
  - busy 0.
- States: IDLE, ENTRY, LOAD, ARM, BUSY.
- Digit entry (IDLE or ENTRY, key_valid=1, key_code<=9, digit_count<3):
  - shift left: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code;
  - digit_count increments by 1;
  - state becomes ENTRY.
- Digit entry when digit_count==3: key ignored; buffer and count unchanged (no wrap).
- key_code 10-15: ignored in every state.
- key_clear in IDLE or ENTRY: all digits 0, digit_count 0, state IDLE.
- start in IDLE (digit_count==0): ignored.
- start in ENTRY with sec_tens > MAX_SEC_TENS: err=1 for one cycle; stay in ENTRY; buffer kept.
- start in ENTRY with valid sec_tens: go to LOAD.
- LOAD → ARM → BUSY; each of LOAD and ARM lasts exactly one cycle.
- BUSY:
  - running falling to 0 → IDLE, buffer cleared;
  - key_clear → cancel=1 for one cycle, then IDLE, buffer cleared;
  - key_valid and start are ignored.
- Priority in the same cycle: key_clear > start > key_valid. A digit presented together with start is dropped.

## Timing
- Start accepted at edge N: loadn=0 during cycle N+1 only. Data digits are stable from N+1 until leaving BUSY.
- start_out=1 during cycle N+2 only, then state BUSY from N+3.
- running is not checked until the cycle after ARM. This gives the counter one cycle to become nonzero after load.
- err and cancel assert in the cycle after the triggering input and last exactly one cycle.
- Digit entry: data and digit_count update one cycle after the key_valid edge.
- Async clrn mid-LOAD or mid-ARM:
  - loadn returns to 1 and start_out to 0 immediately;
  - state goes to IDLE with no further strobes.
- Back-to-back key_valid on consecutive cycles: each digit is accepted.

## Test plan
- Reset, then keys 1,3,0, then start:
  - data min=1, sec_tens=3, sec_ones=0;
  - loadn low 1 cycle at N+1;
  - start_out high 1 cycle at N+2;
  - busy=1.
- Keys 7,8, then start: sec_tens=7 > 5, so err pulses once, no loadn pulse, state stays ENTRY, digit_count=2.
- Keys 1,2,3,4: fourth key ignored; data stays 1:23; digit_count=3.
- Keys 4,5, then key_clear and key_valid(9) in the same cycle: buffer 0, digit_count 0, IDLE.
- Load 0:30, run, hold running=1 for 10 cycles, then drop it: busy falls one cycle later and the buffer is cleared. A repeat run with key_clear while BUSY: cancel pulses once, then IDLE.
- start with an empty buffer: no strobes at all. Then assert clrn low during LOAD of a valid entry: loadn=1 and all outputs at reset values immediately.
